ofm_storer: RTL

- Write-side counterpart of the IFM load path: drains output-feature-map words from the PE array into off-chip SDRAM.
- Accepts a valid/ready word stream.
- Buffers words in a small FIFO.
- Issues SDRAM write strobes at consecutive addresses starting at OFM_BASE + m*OFM_SIZE, stalling on SDRAM_WAIT.
- Pulses done when OFM_SIZE*TM words have been written for one output-map group.

---
 rtl/ofm_storer_pkg.sv | 25 ++
 rtl/ofm_storer_if.sv | 27 ++
 rtl/ofm_storer_fifo.sv | 48 ++++
 rtl/ofm_storer.sv | 103 ++++++++++
 4 files changed

// File: rtl/ofm_storer_pkg.sv
// Shared constants and state encoding for the feature-map SDRAM paths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofm_storer_pkg;

  // SDRAM address width shared by the load and store paths
  localparam int RAM_ADR_W = 32;

  // Input-feature-map load path defaults
  localparam logic [RAM_ADR_W-1:0] IMG_BASE = 32'h0000_0000;
  localparam int                   IFM_SIZE = 256;
  localparam int                   TN       = 4;

  // Output-feature-map store path defaults
  localparam logic [RAM_ADR_W-1:0] OFM_BASE_DEF = 32'h0010_0000;
  localparam int                   OFM_SIZE_DEF = 64;
  localparam int                   TM_DEF       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ofm_storer_if.sv
// PE word stream plus SDRAM write bus between the storer and its environment.
// Latency: n/a (wiring only).
// Backpressure: ofm_ready throttles the PE stream, SDRAM_WAIT stalls writes.
interface ofm_storer_if #(
  parameter int ADR_W  = 32,
  parameter int DATA_W = 16
);
  logic              ofm_valid;
  logic [DATA_W-1:0] ofm_data;
  logic              ofm_ready;
  logic              SDRAM_WE_N;
  logic [ADR_W-1:0]  SDRAM_ADDR;
  logic [DATA_W-1:0] SDRAM_WDATA;
  logic              SDRAM_WAIT;

  // Storer side: consumes the PE stream, masters the SDRAM write bus
  modport master (
    input  ofm_valid, ofm_data, SDRAM_WAIT,
    output ofm_ready, SDRAM_WE_N, SDRAM_ADDR, SDRAM_WDATA
  );

  // Environment side: PE producer and SDRAM model
  modport slave (
    output ofm_valid, ofm_data, SDRAM_WAIT,
    input  ofm_ready, SDRAM_WE_N, SDRAM_ADDR, SDRAM_WDATA
  );
endinterface

// File: rtl/ofm_storer_fifo.sv
// Small synchronous FIFO buffering OFM words between the PE array and SDRAM.
// Latency: a word pushed at cycle t is visible on dout at t+1.
// Backpressure: push ignored when full, pop ignored when empty; both allowed together.
module ofm_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards any buffered words
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ofm_storer.sv
// Drains OFM words from the PE array into SDRAM at OFM_BASE + m*OFM_SIZE + k (OFM_RELU_EN clamps negatives to 0).
// Latency: word accepted at cycle t is on SDRAM_WDATA at t+1 at the earliest.
// Backpressure: ofm_ready low when FIFO full or job quota pushed; SDRAM_WAIT holds the current write.
module ofm_storer
  import ofm_storer_pkg::*;
#(
  parameter int               ADR_W      = RAM_ADR_W,
  parameter int               DATA_W     = 16,
  parameter int               M_IDX_W    = 8,
  parameter int               OFM_SIZE   = OFM_SIZE_DEF,
  parameter int               TM         = TM_DEF,
  parameter logic [ADR_W-1:0] OFM_BASE   = ADR_W'(OFM_BASE_DEF),
  parameter int               FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [M_IDX_W-1:0] m,
  ofm_storer_if.master       bus,
  output logic               busy,
  output logic               done
);
  localparam int TOTAL = OFM_SIZE * TM;
  localparam int CNT_W = $clog2(TOTAL + 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADR_W-1:0]  offset_q;
  logic [CNT_W-1:0]  p_q;
  logic [CNT_W-1:0]  k_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              wr_en;
  logic              wr_done;
  logic [DATA_W-1:0] fifo_din;
  logic [DATA_W-1:0] fifo_dout;

  // Ready depends only on registered state so SDRAM_WAIT never reaches it combinationally
  assign bus.ofm_ready = (state_q == ST_STORE) && !fifo_full && (p_q < CNT_W'(TOTAL));
  assign push          = bus.ofm_valid && bus.ofm_ready;
  assign wr_en         = (state_q == ST_STORE) && !fifo_empty;
  assign wr_done       = wr_en && !bus.SDRAM_WAIT;

  assign bus.SDRAM_WE_N  = !wr_en;
  assign bus.SDRAM_ADDR  = wr_en ? (offset_q + ADR_W'(k_q)) : '0;
  assign bus.SDRAM_WDATA = wr_en ? fifo_dout : '0;

  assign busy = (state_q == ST_STORE);
  assign done = (state_q == ST_DONE);

`ifdef OFM_RELU_EN
  assign fifo_din = bus.ofm_data[DATA_W-1] ? '0 : bus.ofm_data;
`else
  assign fifo_din = bus.ofm_data;
`endif

  ofm_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (wr_done),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State, job offset and push/write counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      offset_q <= '0;
      p_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && enable) begin
        offset_q <= OFM_BASE + ADR_W'(m) * ADR_W'(OFM_SIZE);
        p_q      <= '0;
        k_q      <= '0;
      end else begin
        if (push)    p_q <= p_q + CNT_W'(1);
        if (wr_done) k_q <= k_q + CNT_W'(1);
      end
    end
  end

  // Next state: leave STORE on the completion of the final write
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_STORE;
      ST_STORE: if (wr_done && (k_q == CNT_W'(TOTAL - 1))) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule
